// File: rtl/cnn_sched_pkg.sv
// Shared layer table, state encoding and address helpers
// for the CNN layer scheduler.
package cnn_sched_pkg;

    typedef enum logic [1:0] {
        L_CONV1 = 2'd0,
        L_CONV2 = 2'd1,
        L_CONV3 = 2'd2,
        L_POOL  = 2'd3
    } layer_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_POOL    = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam int unsigned CONV1_GROUPS = 4;
    localparam int unsigned CONV2_GROUPS = 16;
    localparam int unsigned CONV3_GROUPS = 64;

    function automatic int unsigned layer_groups(input layer_e l);
        case (l)
            L_CONV1: return CONV1_GROUPS;
            L_CONV2: return CONV2_GROUPS;
            L_CONV3: return CONV3_GROUPS;
            default: return 1;
        endcase
    endfunction

    function automatic int unsigned layer_wlen(input layer_e l);
        case (l)
            L_CONV1: return 4;
            L_CONV2: return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int unsigned layer_wbase(input layer_e l);
        case (l)
            L_CONV1: return 0;
            L_CONV2: return 16;
            default: return 80;
        endcase
    endfunction

    function automatic int unsigned layer_bbase(input layer_e l);
        case (l)
            L_CONV1: return 0;
            L_CONV2: return 4;
            default: return 20;
        endcase
    endfunction

    function automatic int unsigned weight_addr(input layer_e l,
                                                input int unsigned g);
        return layer_wbase(l) + g * layer_wlen(l);
    endfunction

    function automatic int unsigned bias_addr_of(input layer_e l,
                                                 input int unsigned g);
        return layer_bbase(l) + g;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear,
// used for busy-cycle accounting.
module sat_counter #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (en && (r_q != {W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/layer_scheduler.sv
// Walks CONV1..CONV3 group by group through load/compute,
// then a single pool pass, with registered request pulses.
import cnn_sched_pkg::*;

module layer_scheduler #(
    parameter int WADDR_W = 11,
    parameter int BADDR_W = 7,
    parameter int PERF_W  = 20
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               load_done,
    input  logic               tile_done,
    input  logic               pool_done,
    output logic               load_start,
    output logic [WADDR_W-1:0] weight_base,
    output logic [4:0]         weight_len,
    output logic [BADDR_W-1:0] bias_addr,
    output logic               tile_start,
    output logic               pool_start,
    output logic [1:0]         layer_id,
    output logic [5:0]         group_idx,
    output logic               src_b,
    output logic               busy,
    output logic               layer_finish,
    output logic               done,
    output logic [PERF_W-1:0]  busy_cycles
);

    state_e             r_state;
    layer_e             r_layer;
    logic [5:0]         r_group;
    logic [WADDR_W-1:0] r_wbase;
    logic [4:0]         r_wlen;
    logic [BADDR_W-1:0] r_baddr;
    logic               r_src_b;
    logic               r_busy;
    logic               r_load_start;
    logic               r_tile_start;
    logic               r_pool_start;
    logic               r_finish;
    logic               r_done;

    logic               w_last;
    layer_e             w_nxt_layer;
    logic [5:0]         w_nxt_group;
    logic               w_bc_en;
    logic               w_bc_clr;

    always_comb begin
        w_last      = (r_group == 6'(layer_groups(r_layer) - 1));
        w_nxt_layer = w_last ? layer_e'(r_layer + 2'd1) : r_layer;
        w_nxt_group = w_last ? 6'd0 : r_group + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_layer      <= L_CONV1;
            r_group      <= '0;
            r_wbase      <= '0;
            r_wlen       <= '0;
            r_baddr      <= '0;
            r_src_b      <= 1'b0;
            r_busy       <= 1'b0;
            r_load_start <= 1'b0;
            r_tile_start <= 1'b0;
            r_pool_start <= 1'b0;
            r_finish     <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_load_start <= 1'b0;
            r_tile_start <= 1'b0;
            r_pool_start <= 1'b0;
            r_finish     <= 1'b0;
            r_done       <= 1'b0;
            if (abort && r_busy) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: if (start) begin
                        r_state      <= S_LOAD;
                        r_busy       <= 1'b1;
                        r_layer      <= L_CONV1;
                        r_group      <= '0;
                        r_src_b      <= 1'b0;
                        r_wbase      <= WADDR_W'(weight_addr(L_CONV1, 0));
                        r_wlen       <= 5'(layer_wlen(L_CONV1));
                        r_baddr      <= BADDR_W'(bias_addr_of(L_CONV1, 0));
                        r_load_start <= 1'b1;
                    end
                    S_LOAD: if (load_done) begin
                        r_state      <= S_COMPUTE;
                        r_tile_start <= 1'b1;
                    end
                    S_COMPUTE: if (tile_done) begin
                        r_layer <= w_nxt_layer;
                        r_group <= w_nxt_group;
                        if (w_last) begin
                            r_finish <= 1'b1;
                            r_src_b  <= ~r_src_b;
                        end
                        // Last CONV3 group hands over to the pool pass
                        if (w_last && r_layer == L_CONV3) begin
                            r_state      <= S_POOL;
                            r_pool_start <= 1'b1;
                        end else begin
                            r_state      <= S_LOAD;
                            r_load_start <= 1'b1;
                            r_wbase      <= WADDR_W'(weight_addr(
                                                w_nxt_layer, w_nxt_group));
                            r_wlen       <= 5'(layer_wlen(w_nxt_layer));
                            r_baddr      <= BADDR_W'(bias_addr_of(
                                                w_nxt_layer, w_nxt_group));
                        end
                    end
                    S_POOL: if (pool_done) begin
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                        r_done   <= 1'b1;
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Abort freezes the count; a new start clears it
    assign w_bc_en  = r_busy && !abort;
    assign w_bc_clr = (r_state == S_IDLE) && start;

    sat_counter #(
        .W (PERF_W)
    ) u_busy_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_bc_en),
        .clr   (w_bc_clr),
        .q     (busy_cycles)
    );

    assign load_start   = r_load_start;
    assign weight_base  = r_wbase;
    assign weight_len   = r_wlen;
    assign bias_addr    = r_baddr;
    assign tile_start   = r_tile_start;
    assign pool_start   = r_pool_start;
    assign layer_id     = r_layer;
    assign group_idx    = r_group;
    assign src_b        = r_src_b;
    assign busy         = r_busy;
    assign layer_finish = r_finish;
    assign done         = r_done;

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed bench for layer_scheduler: vector table plus
// full-run, zero-wait, abort and saturation sequences.
module tb_layer_scheduler;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    logic v_ld, v_td, v_pd;
    logic r_ld, r_td, r_pd;
    logic load_done, tile_done, pool_done;

    assign load_done = v_ld | r_ld;
    assign tile_done = v_td | r_td;
    assign pool_done = v_pd | r_pd;

    logic        load_start, tile_start, pool_start;
    logic [10:0] weight_base;
    logic [4:0]  weight_len;
    logic [6:0]  bias_addr;
    logic [1:0]  layer_id;
    logic [5:0]  group_idx;
    logic        src_b, busy, layer_finish, done;
    logic [19:0] busy_cycles;

    logic        s_ls, s_ts, s_ps, s_sb, s_busy, s_lf, s_dn;
    logic [10:0] s_wb;
    logic [4:0]  s_wl;
    logic [6:0]  s_ba;
    logic [1:0]  s_lid;
    logic [5:0]  s_gi;
    logic [3:0]  s_bc;

    always #5 clk = ~clk;

    layer_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .load_done(load_done), .tile_done(tile_done),
        .pool_done(pool_done), .load_start(load_start),
        .weight_base(weight_base), .weight_len(weight_len),
        .bias_addr(bias_addr), .tile_start(tile_start),
        .pool_start(pool_start), .layer_id(layer_id),
        .group_idx(group_idx), .src_b(src_b), .busy(busy),
        .layer_finish(layer_finish), .done(done),
        .busy_cycles(busy_cycles)
    );

    layer_scheduler #(.PERF_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .load_done(load_done), .tile_done(tile_done),
        .pool_done(pool_done), .load_start(s_ls),
        .weight_base(s_wb), .weight_len(s_wl),
        .bias_addr(s_ba), .tile_start(s_ts),
        .pool_start(s_ps), .layer_id(s_lid),
        .group_idx(s_gi), .src_b(s_sb), .busy(s_busy),
        .layer_finish(s_lf), .done(s_dn),
        .busy_cycles(s_bc)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Responder: answers each request resp_d cycles later
    bit resp_en = 0;
    int resp_d  = 3;
    int t_ld = 0, t_td = 0, t_pd = 0;
    initial begin r_ld = 0; r_td = 0; r_pd = 0; end

    always @(negedge clk) begin
        if (!resp_en) begin
            t_ld = 0; t_td = 0; t_pd = 0;
            r_ld = 0; r_td = 0; r_pd = 0;
        end else begin
            r_ld = (t_ld == 1); if (t_ld != 0) t_ld--;
            r_td = (t_td == 1); if (t_td != 0) t_td--;
            r_pd = (t_pd == 1); if (t_pd != 0) t_pd--;
            if (load_start) t_ld = resp_d;
            if (tile_start) t_td = resp_d;
            if (pool_start) t_pd = resp_d;
        end
    end

    // Monitor: cumulative pulse counts and address captures
    int n_ls = 0, n_ts = 0, n_ps = 0, n_lf = 0, n_dn = 0, n_viol = 0;
    logic [7:0]  fin_log = '0;
    logic        p_ls = 0, p_ts = 0, p_ps = 0, p_lf = 0, p_dn = 0;
    logic [10:0] c3_wb = '0, c2_wb = '1;
    logic [4:0]  c3_wl = '0;
    logic [6:0]  c3_ba = '0, c2_ba = '1;
    logic        c2_sb = 0;

    always @(negedge clk) begin
        if (load_start) n_ls++;
        if (tile_start) n_ts++;
        if (pool_start) n_ps++;
        if (done) n_dn++;
        if (layer_finish) begin
            n_lf++;
            fin_log = {fin_log[5:0], layer_id};
        end
        if ((load_start && p_ls) || (tile_start && p_ts) ||
            (pool_start && p_ps) || (layer_finish && p_lf) ||
            (done && p_dn)) n_viol++;
        if (load_start && layer_id == 2 && group_idx == 63) begin
            c3_wb = weight_base; c3_wl = weight_len; c3_ba = bias_addr;
        end
        if (load_start && layer_id == 1 && group_idx == 0) begin
            c2_wb = weight_base; c2_ba = bias_addr; c2_sb = src_b;
        end
        p_ls = load_start; p_ts = tile_start; p_ps = pool_start;
        p_lf = layer_finish; p_dn = done;
    end

    typedef struct packed {
        logic        rst_n, start, abort, ld, td, pd;
        logic        busy;
        logic [1:0]  layer;
        logic [5:0]  grp;
        logic        ls, ts, ps, lf, dn;
        logic [19:0] bc;
        logic [10:0] wb;
    } vec_t;

    vec_t tbl [14];

    task automatic run_to_done(input int d, input string nm);
        int base;
        int c;
        base = n_dn;
        resp_d = d; resp_en = 1;
        start = 1; @(negedge clk); start = 0;
        c = 0;
        while (n_dn == base && c < 5000) begin
            @(negedge clk); c++;
        end
        chk({nm, "_done_seen"}, n_dn - base, 1);
        repeat (2) @(negedge clk);
        resp_en = 0;
    endtask

    initial begin
        int b_ls, b_ts, b_ps, b_lf, b_dn, c;
        logic [19:0] bc_hold;
        rst_n = 0; start = 0; abort = 0;
        v_ld = 0; v_td = 0; v_pd = 0;

        //          rst st ab ld td pd  bsy ly g  ls ts ps lf dn bc wb
        tbl[0]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tbl[5]  = '{1, 0, 0, 0, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0, 2, 0};
        tbl[6]  = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 3, 0};
        tbl[7]  = '{1, 0, 0, 1, 0, 0,  1, 0, 0, 0, 1, 0, 0, 0, 4, 0};
        tbl[8]  = '{1, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 5, 0};
        tbl[9]  = '{1, 0, 0, 0, 1, 0,  1, 0, 1, 1, 0, 0, 0, 0, 6, 4};
        tbl[10] = '{1, 0, 0, 1, 0, 0,  1, 0, 1, 0, 1, 0, 0, 0, 7, 4};
        tbl[11] = '{1, 0, 0, 0, 1, 0,  1, 0, 2, 1, 0, 0, 0, 0, 8, 8};
        tbl[12] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[13] = '{1, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0, 0, 0, 0};

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            rst_n = tbl[i].rst_n; start = tbl[i].start;
            abort = tbl[i].abort; v_ld = tbl[i].ld;
            v_td = tbl[i].td; v_pd = tbl[i].pd;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {busy, layer_id, group_idx, load_start, tile_start,
                 pool_start, layer_finish, done, busy_cycles,
                 weight_base},
                {tbl[i].busy, tbl[i].layer, tbl[i].grp, tbl[i].ls,
                 tbl[i].ts, tbl[i].ps, tbl[i].lf, tbl[i].dn,
                 tbl[i].bc, tbl[i].wb});
        end
        start = 0; v_ld = 0; v_td = 0; v_pd = 0;

        // Full run, 3-cycle responses
        rst_n = 0; @(negedge clk); rst_n = 1;
        b_ls = n_ls; b_ts = n_ts; b_ps = n_ps; b_lf = n_lf;
        run_to_done(3, "full");
        chk("full_load_starts", n_ls - b_ls, 84);
        chk("full_tile_starts", n_ts - b_ts, 84);
        chk("full_pool_starts", n_ps - b_ps, 1);
        chk("full_finishes", n_lf - b_lf, 4);
        chk("full_finish_layers", fin_log, 8'h6F);
        chk("full_busy_cycles", busy_cycles, 677);
        chk("full_idle_after", busy, 0);
        chk("sat_busy_cycles", s_bc, 15);
        chk("c3g63_addr", {c3_wb, c3_wl, c3_ba}, {11'd1088, 5'd16, 7'd83});
        chk("c2g0_addr", {c2_wb, c2_ba, c2_sb}, {11'd16, 7'd4, 1'b1});

        // Zero-wait responses
        b_ls = n_ls; b_ts = n_ts; b_ps = n_ps;
        run_to_done(1, "zw");
        chk("zw_load_starts", n_ls - b_ls, 84);
        chk("zw_tile_starts", n_ts - b_ts, 84);
        chk("zw_pool_starts", n_ps - b_ps, 1);
        chk("zw_busy_cycles", busy_cycles, 339);

        // Abort during CONV2 group 7
        b_dn = n_dn;
        resp_d = 3; resp_en = 1;
        start = 1; @(negedge clk); start = 0;
        c = 0;
        while (!(load_start && layer_id == 1 && group_idx == 7) &&
               c < 2000) begin
            @(negedge clk); c++;
        end
        chk("abort_reached_c2g7", {layer_id, group_idx}, {2'd1, 6'd7});
        b_lf = n_lf;
        bc_hold = busy_cycles;
        abort = 1; @(negedge clk); abort = 0; resp_en = 0;
        chk("abort_idle", busy, 0);
        chk("abort_bc_held", busy_cycles, bc_hold);
        repeat (8) @(negedge clk);
        chk("abort_no_done", n_dn - b_dn, 0);
        chk("abort_no_finish", n_lf - b_lf, 0);
        chk("abort_still_idle", {busy, busy_cycles}, {1'b0, bc_hold});
        start = 1; @(negedge clk); start = 0;
        chk("restart_state",
            {busy, load_start, layer_id, group_idx, busy_cycles, src_b},
            {1'b1, 1'b1, 2'd0, 6'd0, 20'd0, 1'b0});

        rst_n = 0; @(negedge clk); rst_n = 1;
        chk("pulse_overlap", n_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
LAYER_SCHEDULER -- requirements
Module: layer_scheduler

Interface
REQ-001 SHALL have parameter WADDR_W, default 11, meaning weight SRAM address width.
REQ-002 SHALL have parameter BADDR_W, default 7, meaning bias SRAM address width.
REQ-003 SHALL have parameter PERF_W, default 20, meaning busy-cycle counter width.
REQ-004 SHALL have ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  pulse that begins a full-network run.
- abort  input  1  synchronous abandon of the run.
- load_done  input  1  pulse from the weight/bias loader when the group is loaded.
- tile_done  input  1  pulse from the conv engine when the group output is written.
- pool_done  input  1  pulse from the pool engine when pooling is done.
- load_start  output  1  one-cycle request to load one output-channel group.
- weight_base  output  WADDR_W  first weight address of the current group.
- weight_len  output  5  weight words per group (4 or 16).
- bias_addr  output  BADDR_W  bias address of the current group.
- tile_start  output  1  one-cycle request to compute the current group.
- pool_start  output  1  one-cycle request to run the pool stage.
- layer_id  output  2  current layer: 0=CONV1, 1=CONV2, 2=CONV3, 3=POOL.
- group_idx  output  6  current output-channel group within the layer.
- src_b  output  1  0: read group A and write group B; 1: read B and write A.
- busy  output  1  high in every state except IDLE.
- layer_finish  output  1  one-cycle pulse when a layer's last group or pool completes.
- done  output  1  one-cycle pulse at run completion.
- busy_cycles  output  PERF_W  saturating count of busy cycles in the last or current run.

Function
REQ-005 SHALL implement states IDLE, LOAD, COMPUTE, POOL, DONE.
REQ-006 SHALL register all outputs; no combinational input-to-output paths.
REQ-007 SHALL use the following layer table:
- CONV1: 4 groups, 4 words, weight base 0, bias base 0, src_b=0.
- CONV2: 16 groups, 4 words, weight base 16, bias base 4, src_b=1.
- CONV3: 64 groups, 16 words, weight base 80, bias base 20, src_b=0.
- POOL: src_b=1.
REQ-008 SHALL compute weight_base = layer weight base + group_idx*weight_len, and bias_addr = layer bias base + group_idx.
REQ-009 SHALL handle IDLE+start as follows: next cycle LOAD, layer_id=0, group_idx=0, load_start=1 for exactly that first LOAD cycle, busy_cycles cleared to 0.
REQ-010 SHALL handle LOAD+load_done as follows: next cycle COMPUTE, tile_start=1 for exactly the first COMPUTE cycle.
REQ-011 SHALL handle COMPUTE+tile_done in three cases:
- Group not last: group_idx+1, then LOAD with a load_start pulse.
- Last group of CONV1 or CONV2: layer_finish=1, layer_id+1, group_idx=0, src_b toggles, then LOAD with a load_start pulse.
- Last group of CONV3: layer_finish=1, layer_id=3, then POOL with pool_start=1 in its first cycle.
REQ-012 SHALL handle POOL+pool_done as follows: next cycle DONE with layer_finish=1 and done=1, and the cycle after that IDLE.
REQ-013 SHALL ignore an input pulse that arrives outside its state (load_done outside LOAD, tile_done outside COMPUTE, pool_done outside POOL, start outside IDLE).
REQ-014 SHALL let abort take priority over all other inputs when busy: next cycle IDLE, no done, no layer_finish, busy_cycles held.
REQ-015 SHALL increment busy_cycles on every cycle busy=1 and saturate at 2^PERF_W-1.
REQ-016 SHALL drive load_start, tile_start, pool_start, layer_finish and done as single-cycle pulses, never asserted two cycles in a row.
REQ-017 SHALL take zero-wait transitions: a done pulse in the cycle after its start pulse is legal.

Reset
REQ-018 SHALL, with rst_n=0 at a clock edge, enter IDLE and clear all outputs and counters to 0, including mid-run; no pulse is emitted in the cycle after reset.

Structure
REQ-019 SHALL take the layer enum, the per-layer group counts, word counts and base addresses, and the state encoding from a shared package, cnn_sched_pkg.
REQ-020 SHALL implement busy_cycles in one sub-module, sat_counter (enable, clear, saturating).

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Full run with load_done/tile_done returned 3 cycles after each request -> 84 load_start, 84 tile_start, 1 pool_start, layer_finish pulses at the CONV1, CONV2, CONV3 and POOL ends, then one done.
- CONV3 group 63 -> weight_base=1088, weight_len=16, bias_addr=83; CONV2 group 0 -> weight_base=16, bias_addr=4, src_b=1.
- Zero-wait loader/engine (done pulses in the cycle after each request) -> no lost pulse, total busy_cycles matches the computed cycle count.
- Spurious tile_done in LOAD and load_done in COMPUTE -> no state change; start while busy -> ignored.
- abort during CONV2 group 7 -> IDLE next cycle, done stays 0; a new start -> restarts at CONV1 group 0 with busy_cycles=0.
- rst_n=0 mid-CONV1, then start -> clean restart; PERF_W=4 with a long run -> busy_cycles saturates at 15.
